// File: rtl/acumulador_4bits_pkg.sv
// acumulador_4bits_pkg: FSM state encoding and accumulator width shared by the accumulator files
package acumulador_4bits_pkg;
  localparam int ACC_W = 8;
  typedef enum logic [1:0] {IDLE, ADD_LO, ADD_HI, DONE} state_t;
endpackage

// File: rtl/acumulador_4bits_if.sv
// acumulador_4bits_if: operand handshake plus result/status bus (master drives clear/in_valid/in_data)
interface acumulador_4bits_if;
  import acumulador_4bits_pkg::*;
  logic clear;
  logic in_valid;
  logic [3:0] in_data;
  logic in_ready;
  logic [ACC_W-1:0] acc;
  logic out_valid;
  logic overflow;
  logic busy;
  modport master (output clear, in_valid, in_data, input in_ready, acc, out_valid, overflow, busy);
  modport slave (input clear, in_valid, in_data, output in_ready, acc, out_valid, overflow, busy);
endinterface

// File: rtl/somador_4bits.sv
// somador_4bits: 4-bit adder with carry in/out (A, B, Cin -> S, Cout)
module somador_4bits (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);
  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {4'b0, Cin};
endmodule

// File: rtl/acumulador_4bits.sv
// acumulador_4bits: 8-bit running sum of 4-bit operands, one nibble per cycle through a single adder (clk, rst_n, bus)
module acumulador_4bits
  import acumulador_4bits_pkg::*;
(
  input logic clk,
  input logic rst_n,
  acumulador_4bits_if.slave bus
);
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0] operand_q, operand_d, sum;
  logic carry_q, carry_d, overflow_q, overflow_d, out_valid_q, out_valid_d, busy_q, busy_d, cout, hi;
  assign hi = state_q == ADD_HI;
  somador_4bits u_add (
    .A(hi ? acc_q[7:4] : acc_q[3:0]),
    .B(hi ? 4'h0 : operand_q),
    .Cin(hi & carry_q),
    .S(sum),
    .Cout(cout)
  );
  assign bus.in_ready = rst_n && !bus.clear && state_q == IDLE;
  assign bus.acc = acc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow = overflow_q;
  assign bus.busy = busy_q;
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    operand_d = operand_q;
    carry_d = carry_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: if (bus.in_valid && bus.in_ready) begin
        operand_d = bus.in_data;
        state_d = ADD_LO;
      end
      ADD_LO: begin
        acc_d[3:0] = sum;
        carry_d = cout;
        state_d = ADD_HI;
      end
      ADD_HI: begin
        acc_d[7:4] = sum;
        overflow_d = overflow_q | cout;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.clear) begin
      state_d = IDLE;
      acc_d = '0;
      carry_d = 1'b0;
      overflow_d = 1'b0;
    end
    out_valid_d = state_d == DONE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      operand_q <= 4'h0;
      carry_q <= 1'b0;
      overflow_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      operand_q <= operand_d;
      carry_q <= carry_d;
      overflow_q <= overflow_d;
      out_valid_q <= out_valid_d;
      busy_q <= busy_d;
    end
endmodule

// File: tb/tb_acumulador_4bits.sv
// tb_acumulador_4bits: directed self-checking bench for acumulador_4bits
module tb_acumulador_4bits;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int hs, rdy_bad;
  acumulador_4bits_if bus ();
  acumulador_4bits dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask
  task automatic chk_b(input string tag, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask
  task automatic op(input logic [3:0] d, input logic [7:0] exp_acc);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    chk_b("ready_idle", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_b("busy_add_lo", bus.busy, 1'b1);
    chk_b("ready_add_lo", bus.in_ready, 1'b0);
    chk_b("valid_add_lo", bus.out_valid, 1'b0);
    @(negedge clk);
    chk_b("valid_add_hi", bus.out_valid, 1'b0);
    @(negedge clk);
    chk_b("valid_done", bus.out_valid, 1'b1);
    chk("acc_done", bus.acc, exp_acc);
    @(negedge clk);
    chk_b("valid_back_idle", bus.out_valid, 1'b0);
    chk_b("ready_back_idle", bus.in_ready, 1'b1);
  endtask
  task automatic clear_pulse();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    #1;
  endtask
  initial begin
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 4'h0;
    #3;
    chk_b("rst_ready", bus.in_ready, 1'b0);
    chk("rst_acc", bus.acc, 8'h00);
    chk_b("rst_busy", bus.busy, 1'b0);
    chk_b("rst_valid", bus.out_valid, 1'b0);
    chk_b("rst_overflow", bus.overflow, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_b("ready_after_rst", bus.in_ready, 1'b1);
    op(4'h2, 8'h02);
    op(4'h6, 8'h08);
    chk_b("ovf_small", bus.overflow, 1'b0);
    clear_pulse();
    chk("acc_cleared", bus.acc, 8'h00);
    for (int i = 0; i < 17; i++) op(4'hF, 8'(15 * (i + 1)));
    chk("acc_ff", bus.acc, 8'hFF);
    chk_b("ovf_ff", bus.overflow, 1'b0);
    op(4'h1, 8'h00);
    chk_b("ovf_wrap", bus.overflow, 1'b1);
    op(4'h3, 8'h03);
    chk_b("ovf_sticky", bus.overflow, 1'b1);
    op(4'hB, 8'h0E);
    chk_b("ovf_still_set", bus.overflow, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 4'h5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("acc_low_nibble", bus.acc, 8'h03);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    #1;
    chk("clr_hi_acc", bus.acc, 8'h00);
    chk_b("clr_hi_ovf", bus.overflow, 1'b0);
    chk_b("clr_hi_busy", bus.busy, 1'b0);
    chk_b("clr_hi_valid", bus.out_valid, 1'b0);
    chk_b("clr_hi_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    chk_b("clr_hi_no_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    bus.clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 4'h7;
    #1;
    chk_b("clr_vs_valid_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    bus.clear = 1'b0;
    #1;
    chk_b("clr_vs_valid_busy", bus.busy, 1'b0);
    chk("clr_vs_valid_acc", bus.acc, 8'h00);
    chk_b("clr_vs_valid_ready2", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_b("late_accept_busy", bus.busy, 1'b1);
    repeat (2) @(negedge clk);
    chk_b("late_accept_valid", bus.out_valid, 1'b1);
    chk("late_accept_acc", bus.acc, 8'h07);
    @(negedge clk);
    clear_pulse();
    bus.in_data = 4'h1;
    bus.in_valid = 1'b1;
    hs = 0;
    rdy_bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.in_ready) hs++;
      if (bus.busy && bus.in_ready) rdy_bad++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("stream_handshakes", 8'(hs), 8'd3);
    chk("stream_ready_busy", 8'(rdy_bad), 8'd0);
    chk("stream_acc", bus.acc, 8'h03);
    clear_pulse();
    op(4'hF, 8'h0F);
    op(4'hF, 8'h1E);
    op(4'hF, 8'h2D);
    op(4'hF, 8'h3C);
    op(4'h4, 8'h40);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = 4'h9;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre_rst_acc", bus.acc, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_acc", bus.acc, 8'h00);
    chk_b("mid_rst_busy", bus.busy, 1'b0);
    chk_b("mid_rst_valid", bus.out_valid, 1'b0);
    chk_b("mid_rst_ready", bus.in_ready, 1'b0);
    chk_b("mid_rst_ovf", bus.overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_b("post_rst_no_valid", bus.out_valid, 1'b0);
    end
    chk("post_rst_acc", bus.acc, 8'h00);
    op(4'hA, 8'h0A);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/acumulador_4bits.md
ACUMULADOR_4BITS -- requirements
Module: acumulador_4bits

Interface
REQ-001 SHALL have ports: one clock; reset asynchronous and active-low. Ports in order below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 clear  input  1  synchronous clear of accumulator and flags.
REQ-005 in_valid  input  1  in_data holds an operand.
REQ-006 in_data  input  4  unsigned operand.
REQ-007 in_ready  output  1  block can accept an operand this cycle.
REQ-008 acc  output  8  unsigned running sum, registered.
REQ-009 out_valid  output  1  one-cycle pulse: acc holds the result of the latest operand.
REQ-010 overflow  output  1  sticky: some accumulation exceeded 255.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL use a four-state FSM: IDLE, ADD_LO, ADD_HI, DONE.
REQ-013 in_ready SHALL equal (state==IDLE) && !clear; handshake occurs on a rising edge with in_valid && in_ready.
REQ-014 On handshake SHALL capture in_data into an operand register and go IDLE->ADD_LO.
REQ-015 ADD_LO: adder A=acc[3:0], B=operand, Cin=0; at the edge acc[3:0]<=S, carry register<=Cout, go ADD_HI.
REQ-016 ADD_HI: adder A=acc[7:4], B=4'b0000, Cin=carry register; at the edge acc[7:4]<=S, overflow<=overflow|Cout, go DONE.
REQ-017 DONE: out_valid=1 for exactly this cycle; next edge go IDLE unconditionally.
REQ-018 Latency: handshake at edge k -> acc final after edge k+2 -> out_valid high between edges k+2 and k+3 -> in_ready high again after edge k+3; max throughput one operand per 4 cycles.
REQ-019 Arithmetic SHALL wrap modulo 256 (255+1 -> 0x00) and set overflow on the wrap.
REQ-020 overflow SHALL stay set until clear or reset.
REQ-021 in_valid outside IDLE SHALL be ignored, not queued; the operand SHALL be held by upstream until in_ready.
REQ-022 clear SHALL take priority over all else in every state: next edge acc=0, overflow=0, carry=0, state=IDLE; an in-flight operand is discarded and no out_valid is produced for it.
REQ-023 clear and in_valid both high in IDLE: clear wins, operand not accepted (in_ready low).
REQ-024 acc SHALL change only at ADD_LO/ADD_HI edges, on clear, or on reset.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, acc=8'h00, operand=4'h0, carry=0, overflow=0, out_valid=0, busy=0.
REQ-026 in_ready SHALL be 0 while rst_n is low and 1 from the first cycle after release (clear low).
REQ-027 Reset asserted mid-operation SHALL abort it with no out_valid pulse.

Structure
REQ-028 FSM state encodings and the accumulator width (8) SHALL reside in a shared package.
REQ-029 The nibble adder SHALL be one instance of the existing sub-module somador_4bits (ports A, B, Cin, S, Cout); no other arithmetic operators.
REQ-030 All other logic SHALL be the FSM plus operand, carry, acc and overflow registers.

Verification
REQ-031 Reset then operands 4'h2 and 4'h6 -> out_valid pulses 2 cycles after each handshake; acc=0x02, then 0x08; overflow=0.
REQ-032 Seventeen operands 4'hF -> acc=0xFF, overflow=0; one more 4'h1 -> acc=0x00, overflow=1; a further 4'h3 -> acc=0x03, overflow still 1.
REQ-033 in_valid held high continuously with in_data=4'h1 for 12 cycles -> exactly 3 handshakes, in_ready low in ADD_LO/ADD_HI/DONE, acc=0x03.
REQ-034 acc=0x0E, operand 4'h5 accepted, clear asserted during ADD_HI -> next edge acc=0x00, overflow=0, state IDLE, no out_valid.
REQ-035 rst_n pulsed low mid-ADD_LO with acc=0x40 -> outputs reach reset values immediately; no out_valid; next operand 4'hA gives acc=0x0A.
REQ-036 clear and in_valid (4'h7) high together in IDLE -> no handshake, acc=0x00; operand accepted next cycle -> acc=0x07.
